// File: rtl/xdscl_pkg.sv
// rtl/xdscl_pkg.sv - shared types and constants for the xdscl scaler
package xdscl_pkg;

  localparam int LANES   = 4;
  localparam int LANE_W  = 32;
  localparam int SCALE_W = 16;
  localparam int CNT_W   = 16;
  localparam int SHIFT_W = 5;
  localparam int PROD_W  = LANE_W + SCALE_W;
  localparam int DATA_W  = LANES * LANE_W;
  localparam int NSAT_W  = $clog2(LANES + 1);

  localparam logic [LANE_W-1:0] SAT_MAX = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0] SAT_MIN = {1'b1, {(LANE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    XDSCL_IDLE,
    XDSCL_RUN,
    XDSCL_DRAIN
  } xdscl_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } xdscl_beat_t;

endpackage

// File: rtl/xdscl_if.sv
// rtl/xdscl_if.sv - filter-side input and DMA-side output stream bundle
interface xdscl_if;
  import xdscl_pkg::*;

  logic              xdfil2scl_valid;
  logic [DATA_W-1:0] xdfil2scl_data;
  logic              xdfil2scl_stall;
  logic              scl2dma_valid;
  logic [DATA_W-1:0] scl2dma_data;
  logic              scl2dma_last;
  logic              scl2dma_stall;

  modport slave (
    input  xdfil2scl_valid, xdfil2scl_data, scl2dma_stall,
    output xdfil2scl_stall, scl2dma_valid, scl2dma_data, scl2dma_last
  );

  modport master (
    output xdfil2scl_valid, xdfil2scl_data, scl2dma_stall,
    input  xdfil2scl_stall, scl2dma_valid, scl2dma_data, scl2dma_last
  );

endinterface

// File: rtl/xdscl_lane.sv
// rtl/xdscl_lane.sv - one lane: signed multiply, round-half-up, shift, saturate
module xdscl_lane
  import xdscl_pkg::*;
(
  input  logic [LANE_W-1:0]  lane_i,
  input  logic [SCALE_W-1:0] scale_i,
  input  logic [SHIFT_W-1:0] shift_i,
  output logic [LANE_W-1:0]  res_o,
  output logic               sat_o
);

  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] rnd;
  logic signed [PROD_W-1:0] shifted;
  logic [PROD_W-LANE_W:0]   hi;

  // Product is at most 2^46 in magnitude, so adding the rounding bit cannot overflow
  always_comb begin
    prod    = $signed({{(PROD_W-LANE_W){lane_i[LANE_W-1]}}, lane_i}) *
              $signed({{(PROD_W-SCALE_W){scale_i[SCALE_W-1]}}, scale_i});
    rnd     = (shift_i == '0) ? '0 : (PROD_W'(1) << (shift_i - SHIFT_W'(1)));
    shifted = (prod + rnd) >>> shift_i;
    hi      = shifted[PROD_W-1:LANE_W-1];
    sat_o   = !((&hi) || !(|hi));
    if (sat_o) begin
      res_o = shifted[PROD_W-1] ? SAT_MIN : SAT_MAX;
    end else begin
      res_o = shifted[LANE_W-1:0];
    end
  end

endmodule

// File: rtl/xdscl.sv
// rtl/xdscl.sv - framed scale/round/saturate stage between filter and DMA writer
module xdscl
  import xdscl_pkg::*;
(
  input  logic               xdscl_clk,
  input  logic               xdscl_rst_n,
  xdscl_if.slave             bus,
  input  logic               scl_start,
  input  logic               scl_abort,
  input  logic [SCALE_W-1:0] scl_cfg_scale,
  input  logic [SHIFT_W-1:0] scl_cfg_shift,
  input  logic [CNT_W-1:0]   scl_cfg_frame_len,
  output logic               xdscl_busy,
  output logic               xdscl_intr,
  output logic [CNT_W-1:0]   xdscl_sat_cnt
);

  xdscl_state_e       state_q, state_d;
  logic [SCALE_W-1:0] scale_q;
  logic [SHIFT_W-1:0] shift_q;
  logic [CNT_W-1:0]   len_q;
  logic [CNT_W-1:0]   beat_cnt_q;
  logic               aborted_q, aborted_d;
  logic               intr_q, intr_d;
  logic               start_frame;
  logic               s1_valid_q, s2_valid_q;
  xdscl_beat_t        s1_q, s2_q;
  logic [CNT_W-1:0]   sat_cnt_q;
  logic [CNT_W:0]     sat_sum;
  logic               s2_load, s1_adv, in_ready, in_xfer, in_last;
  logic [DATA_W-1:0]  lane_res;
  logic [LANES-1:0]   lane_sat;
  logic [NSAT_W-1:0]  nsat;

  assign s2_load  = !s2_valid_q || !bus.scl2dma_stall;
  assign s1_adv   = s1_valid_q && s2_load;
  assign in_ready = (state_q == XDSCL_RUN) && (!s1_valid_q || s1_adv);
  assign in_xfer  = in_ready && bus.xdfil2scl_valid;
  assign in_last  = (beat_cnt_q == len_q - CNT_W'(1));

  assign bus.xdfil2scl_stall = !in_ready;
  assign bus.scl2dma_valid   = s2_valid_q;
  assign bus.scl2dma_data    = s2_q.data;
  assign bus.scl2dma_last    = s2_q.last;
  assign xdscl_busy          = (state_q != XDSCL_IDLE);
  assign xdscl_intr          = intr_q;
  assign xdscl_sat_cnt       = sat_cnt_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    xdscl_lane u_lane (
      .lane_i  (s1_q.data[i*LANE_W +: LANE_W]),
      .scale_i (scale_q),
      .shift_i (shift_q),
      .res_o   (lane_res[i*LANE_W +: LANE_W]),
      .sat_o   (lane_sat[i])
    );
  end

  // Count saturated lanes of the beat currently in S1
  always_comb begin
    nsat = '0;
    for (int i = 0; i < LANES; i++) begin
      nsat = nsat + NSAT_W'(lane_sat[i]);
    end
    sat_sum = {1'b0, sat_cnt_q} + (CNT_W+1)'(nsat);
  end

  // Frame FSM: next state, abort tracking and completion pulse
  always_comb begin
    state_d     = state_q;
    aborted_d   = aborted_q;
    intr_d      = 1'b0;
    start_frame = 1'b0;
    case (state_q)
      XDSCL_IDLE: begin
        if (scl_start) begin
          state_d     = XDSCL_RUN;
          start_frame = 1'b1;
          aborted_d   = 1'b0;
        end
      end
      XDSCL_RUN: begin
        if (scl_abort) begin
          state_d   = XDSCL_DRAIN;
          aborted_d = 1'b1;
        end else if (in_xfer && in_last) begin
          state_d = XDSCL_DRAIN;
        end
      end
      XDSCL_DRAIN: begin
        if (!s1_valid_q && !s2_valid_q) begin
          state_d   = XDSCL_IDLE;
          intr_d    = !aborted_q;
          aborted_d = 1'b0;
        end
      end
      default: state_d = XDSCL_IDLE;
    endcase
  end

  // FSM state, config latch and beat counter; len 0 is stored as 1
  always_ff @(posedge xdscl_clk or negedge xdscl_rst_n) begin
    if (!xdscl_rst_n) begin
      state_q    <= XDSCL_IDLE;
      aborted_q  <= 1'b0;
      intr_q     <= 1'b0;
      scale_q    <= '0;
      shift_q    <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      aborted_q <= aborted_d;
      intr_q    <= intr_d;
      if (start_frame) begin
        scale_q    <= scl_cfg_scale;
        shift_q    <= scl_cfg_shift;
        len_q      <= (scl_cfg_frame_len == '0) ? CNT_W'(1) : scl_cfg_frame_len;
        beat_cnt_q <= '0;
      end else if (in_xfer) begin
        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
      end
    end
  end

  // Two-stage pipeline; an aborting cycle never tags its beat as last
  always_ff @(posedge xdscl_clk or negedge xdscl_rst_n) begin
    if (!xdscl_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
    end else begin
      if (in_xfer) begin
        s1_valid_q <= 1'b1;
        s1_q.data  <= bus.xdfil2scl_data;
        s1_q.last  <= in_last && !scl_abort;
      end else if (s1_adv) begin
        s1_valid_q <= 1'b0;
      end
      if (s2_load) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_q.data <= lane_res;
          s2_q.last <= s1_q.last;
        end
      end
    end
  end

  // Saturation event counter, sticky at all-ones, cleared when a frame starts
  always_ff @(posedge xdscl_clk or negedge xdscl_rst_n) begin
    if (!xdscl_rst_n) begin
      sat_cnt_q <= '0;
    end else if (start_frame) begin
      sat_cnt_q <= '0;
    end else if (s1_adv) begin
      sat_cnt_q <= sat_sum[CNT_W] ? '1 : sat_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_xdscl.sv
// tb/tb_xdscl.sv - self-checking bench for xdscl
module tb_xdscl;
  import xdscl_pkg::*;

  typedef struct {
    logic [127:0] din;
    logic [15:0]  scale;
    logic [4:0]   shift;
    logic [127:0] dout;
    int           sat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scl_start, scl_abort;
  logic [15:0] cfg_scale, cfg_len;
  logic [4:0]  cfg_shift;
  logic        busy, intr;
  logic [15:0] sat_cnt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int intr_cnt = 0;
  xdscl_beat_t  got_q[$];
  int           out_cyc_q[$];
  int           in_cyc_q[$];
  logic [127:0] in_q[$];
  bit stall_force = 0;
  bit stall_rand = 0;
  vec_t vt[7];

  xdscl_if bus ();

  xdscl dut (
    .xdscl_clk         (clk),
    .xdscl_rst_n       (rst_n),
    .bus               (bus),
    .scl_start         (scl_start),
    .scl_abort         (scl_abort),
    .scl_cfg_scale     (cfg_scale),
    .scl_cfg_shift     (cfg_shift),
    .scl_cfg_frame_len (cfg_len),
    .xdscl_busy        (busy),
    .xdscl_intr        (intr),
    .xdscl_sat_cnt     (sat_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    bus.scl2dma_stall = stall_force || (stall_rand && ($urandom_range(0, 2) == 0));
  end

  always @(negedge clk) begin : monitor
    xdscl_beat_t o;
    if (rst_n === 1'b1) begin
      if (bus.xdfil2scl_valid && !bus.xdfil2scl_stall) begin
        acc_cnt++;
        in_cyc_q.push_back(cyc);
      end
      if (bus.scl2dma_valid && !bus.scl2dma_stall) begin
        o.data = bus.scl2dma_data;
        o.last = bus.scl2dma_last;
        got_q.push_back(o);
        out_cyc_q.push_back(cyc);
      end
      if (intr) intr_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] pack4(input int a, input int b, input int c, input int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  // Reference: exact integer arithmetic, floor shift, then clamp to the 32-bit range
  function automatic logic [31:0] ref_lane(input logic [31:0] l, input logic [15:0] s,
                                           input logic [4:0] sh, output int sat);
    longint p;
    p = longint'($signed(l)) * longint'($signed(s));
    if (sh != 0) p = p + (longint'(1) << (sh - 1));
    p = p >>> sh;
    sat = 1;
    if (p > 64'sd2147483647) return 32'h7FFFFFFF;
    if (p < -64'sd2147483648) return 32'h80000000;
    sat = 0;
    return p[31:0];
  endfunction

  function automatic logic [127:0] ref_beat(input logic [127:0] d, input logic [15:0] s,
                                            input logic [4:0] sh, output int nsat);
    logic [127:0] r;
    int st;
    nsat = 0;
    for (int i = 0; i < 4; i++) begin
      r[i*32 +: 32] = ref_lane(d[i*32 +: 32], s, sh, st);
      nsat += st;
    end
    return r;
  endfunction

  task automatic send_beat(input logic [127:0] d, output bit ok);
    ok = 0;
    bus.xdfil2scl_valid = 1'b1;
    bus.xdfil2scl_data  = d;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (!bus.xdfil2scl_stall) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.xdfil2scl_valid = 1'b0;
  endtask

  task automatic pulse_start(input int len_cfg, input logic [15:0] sc, input logic [4:0] sh);
    cfg_scale = sc;
    cfg_shift = sh;
    cfg_len   = 16'(len_cfg);
    scl_start = 1'b1;
    @(posedge clk);
    #1;
    scl_start = 1'b0;
    cfg_scale = 16'($urandom);
    cfg_shift = 5'($urandom);
    cfg_len   = 16'($urandom);
    chk("busy_after_start", 128'(busy), 128'(1));
  endtask

  // Runs one frame from in_q; abort_after < 0 means run to completion
  task automatic run_frame(input int len_cfg, input logic [15:0] sc, input logic [4:0] sh,
                           input int abort_after, input bit gaps, input bit chk_lat);
    int eff, n, gb, ib, ab, icb, nsat, sat_exp;
    bit ok, idle;
    logic [127:0] exp;
    eff = (len_cfg == 0) ? 1 : len_cfg;
    n   = (abort_after >= 0) ? abort_after : eff;
    gb  = got_q.size();
    icb = in_cyc_q.size();
    ib  = intr_cnt;
    ab  = acc_cnt;
    pulse_start(len_cfg, sc, sh);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_beat(in_q[i], ok);
      if (!ok) chk("accept_timeout", 128'(0), 128'(1));
    end
    if (abort_after >= 0) begin
      scl_abort = 1'b1;
      @(posedge clk);
      #1;
      scl_abort = 1'b0;
      bus.xdfil2scl_valid = 1'b1;
      bus.xdfil2scl_data  = 128'($urandom);
      repeat (6) @(negedge clk);
      chk("abort_no_extra_accept", 128'(acc_cnt - ab), 128'(n));
      @(posedge clk);
      #1;
      bus.xdfil2scl_valid = 1'b0;
    end
    idle = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (!busy) begin
        idle = 1;
        break;
      end
    end
    chk("drain_to_idle", 128'(idle), 128'(1));
    repeat (2) @(negedge clk);
    chk("accepted_count", 128'(acc_cnt - ab), 128'(n));
    chk("out_count", 128'(got_q.size() - gb), 128'(n));
    sat_exp = 0;
    for (int i = 0; i < n; i++) begin
      exp = ref_beat(in_q[i], sc, sh, nsat);
      sat_exp += nsat;
      if (gb + i < got_q.size()) begin
        chk($sformatf("out_data[%0d]", i), got_q[gb+i].data, exp);
        chk($sformatf("out_last[%0d]", i), 128'(got_q[gb+i].last),
            128'((abort_after < 0) && (i == eff - 1)));
        if (chk_lat)
          chk($sformatf("latency[%0d]", i), 128'(out_cyc_q[gb+i] - in_cyc_q[icb+i]), 128'(2));
      end
    end
    if (sat_exp > 65535) sat_exp = 65535;
    chk("intr_pulses", 128'(intr_cnt - ib), 128'((abort_after < 0) ? 1 : 0));
    chk("sat_cnt", 128'(sat_cnt), 128'(sat_exp));
    chk("busy_idle", 128'(busy), 128'(0));
  endtask

  function automatic logic [31:0] rnd_lane();
    case ($urandom_range(0, 3))
      0:       return 32'h7FFFFFFF - 32'($urandom_range(0, 50));
      1:       return 32'h80000000 + 32'($urandom_range(0, 50));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int ab0, gb0, ib0, rlen;
    bit ok;
    logic [15:0] rsc;
    logic [4:0]  rsh;

    vt[0] = '{pack4(1, -1, 100, 0), 16'd2, 5'd0, pack4(2, -2, 200, 0), 0};
    vt[1] = '{pack4(5, -5, 1, -1), 16'd3, 5'd1, pack4(8, -7, 2, -1), 0};
    vt[2] = '{pack4(32'h7FFFFFFF, 32'h80000000, 1, 0), 16'h7FFF, 5'd0,
              pack4(32'h7FFFFFFF, 32'h80000000, 32'h7FFF, 0), 2};
    vt[3] = '{pack4(32'h40000000, -24, 24, 32'h7FFFFFFF), 16'h4000, 5'd31,
              pack4(8192, 0, 0, 16384), 0};
    vt[4] = '{pack4(32'h80000000, 7, -7, 0), 16'hFFFF, 5'd0,
              pack4(32'h7FFFFFFF, -7, 7, 0), 1};
    vt[5] = '{pack4(-24, 24, -8, 8), 16'd1, 5'd4, pack4(-1, 2, 0, 1), 0};
    vt[6] = '{pack4(32'h80000000, 32'h10000, -65536, 3), 16'h8000, 5'd0,
              pack4(32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFE8000), 2};

    rst_n = 1'b0;
    scl_start = 1'b0;
    scl_abort = 1'b0;
    cfg_scale = '0;
    cfg_shift = '0;
    cfg_len   = '0;
    bus.xdfil2scl_valid = 1'b0;
    bus.xdfil2scl_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 128'(bus.scl2dma_valid), 128'(0));
    chk("rst_out_data", bus.scl2dma_data, 128'(0));
    chk("rst_out_last", 128'(bus.scl2dma_last), 128'(0));
    chk("rst_in_stall", 128'(bus.xdfil2scl_stall), 128'(1));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_intr", 128'(intr), 128'(0));
    chk("rst_sat_cnt", 128'(sat_cnt), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic three-beat frame with latency check
    in_q.delete();
    repeat (3) in_q.push_back(pack4(1, -1, 100, 0));
    run_frame(3, 16'd2, 5'd0, -1, 0, 1);

    // Table vectors, each as a single-beat frame
    for (int i = 0; i < 7; i++) begin
      in_q.delete();
      in_q.push_back(vt[i].din);
      run_frame(1, vt[i].scale, vt[i].shift, -1, 0, 0);
      if (got_q.size() > 0) chk($sformatf("tbl_data[%0d]", i), got_q[got_q.size()-1].data, vt[i].dout);
      chk($sformatf("tbl_sat[%0d]", i), 128'(sat_cnt), 128'(vt[i].sat));
    end

    // Backpressure: hold DMA stall for five cycles mid-frame
    in_q.delete();
    for (int i = 0; i < 8; i++) in_q.push_back(pack4(i, -i, 1000 + i, 7 * i));
    ab0 = acc_cnt;
    fork
      run_frame(8, 16'd5, 5'd2, -1, 0, 0);
      begin
        for (int t = 0; t < 300; t++) begin
          @(negedge clk);
          if (acc_cnt - ab0 >= 3) break;
        end
        stall_force = 1;
        repeat (4) @(negedge clk);
        chk("bp_in_stall", 128'(bus.xdfil2scl_stall), 128'(1));
        chk("bp_out_valid", 128'(bus.scl2dma_valid), 128'(1));
        @(negedge clk);
        stall_force = 0;
      end
    join

    // Abort after four beats, then a normal frame
    in_q.delete();
    for (int i = 0; i < 10; i++) in_q.push_back({rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()});
    run_frame(10, 16'h0123, 5'd3, 4, 0, 0);
    run_frame(5, 16'hFF00, 5'd1, -1, 0, 0);

    // Length zero is treated as one
    in_q.delete();
    in_q.push_back(pack4(9, -9, 3, 4));
    run_frame(0, 16'd7, 5'd0, -1, 0, 0);

    // Randomised frames with gaps and random DMA backpressure
    stall_rand = 1;
    for (int f = 0; f < 6; f++) begin
      rlen = $urandom_range(1, 12);
      rsc  = 16'($urandom);
      rsh  = 5'($urandom_range(0, 31));
      in_q.delete();
      for (int i = 0; i < rlen; i++) in_q.push_back({rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()});
      run_frame(rlen, rsc, rsh, -1, 1, 0);
    end
    stall_rand = 0;

    // Asynchronous reset with beats in flight
    stall_force = 1;
    in_q.delete();
    for (int i = 0; i < 4; i++) in_q.push_back(pack4(11 * i, 2, 3, 4));
    gb0 = got_q.size();
    ib0 = intr_cnt;
    pulse_start(8, 16'd3, 5'd0);
    send_beat(in_q[0], ok);
    send_beat(in_q[1], ok);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 128'(bus.scl2dma_valid), 128'(0));
    chk("mrst_out_data", bus.scl2dma_data, 128'(0));
    chk("mrst_out_last", 128'(bus.scl2dma_last), 128'(0));
    chk("mrst_in_stall", 128'(bus.xdfil2scl_stall), 128'(1));
    chk("mrst_busy", 128'(busy), 128'(0));
    chk("mrst_sat_cnt", 128'(sat_cnt), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    stall_force = 0;
    repeat (4) @(negedge clk);
    chk("mrst_no_intr", 128'(intr_cnt - ib0), 128'(0));
    chk("mrst_no_output", 128'(got_q.size() - gb0), 128'(0));
    @(posedge clk);
    #1;
    run_frame(4, 16'd3, 5'd0, -1, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
